// File: rtl/cu_read_line_unpacker_if.sv
// cu_read_line_unpacker_if: command, response-half and element stream signals of the CU read-line unpacker
interface cu_read_line_unpacker_if #(
    parameter int ELEM_BYTES = 4,
    parameter int HALF_BYTES = 64
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [5:0]              cmd_count;
    logic                    line_valid;
    logic                    line_half;
    logic [HALF_BYTES*8-1:0] line_data;
    logic                    line_ready;
    logic                    elem_valid;
    logic                    elem_ready;
    logic [ELEM_BYTES*8-1:0] elem_data;
    logic [5:0]              elem_index;
    logic                    elem_last;
    logic                    err_stray;

    modport master (
        output cmd_valid, cmd_count, line_valid, line_half, line_data, elem_ready,
        input  cmd_ready, line_ready, elem_valid, elem_data, elem_index, elem_last, err_stray
    );

    modport slave (
        input  cmd_valid, cmd_count, line_valid, line_half, line_data, elem_ready,
        output cmd_ready, line_ready, elem_valid, elem_data, elem_index, elem_last, err_stray
    );
endinterface

// File: rtl/cu_read_line_unpacker.sv
// cu_read_line_unpacker: captures a 128 B read line as two halves and streams byte-swapped elements
module cu_read_line_unpacker #(
    parameter int ELEM_BYTES = 4,
    parameter int HALF_BYTES = 64
) (
    input logic                    clock,
    input logic                    reset,
    cu_read_line_unpacker_if.slave bus
);
    localparam int EW = ELEM_BYTES * 8;
    localparam int HE = HALF_BYTES / ELEM_BYTES;
    localparam int KW = $clog2(HE);
    localparam logic [5:0] HE_CNT  = 6'(HE);
    localparam logic [5:0] HE_LAST = 6'(HE - 1);

    typedef enum logic [2:0] {IDLE, WAIT_DATA, SHIFT_0, SHIFT_1, DONE} state_t;

    state_t                  state, state_n;
    logic [5:0]              count, idx;
    logic                    need1, got0, got1;
    logic [HALF_BYTES*8-1:0] buf0, buf1, cur;
    logic [EW-1:0]           words [HE];
    logic [EW-1:0]           raw, swap;
    logic                    rdy, cap0, cap1, shifting, fire, last;

    assign rdy      = state == WAIT_DATA && (bus.line_half ? need1 && !got1 : !got0);
    assign cap0     = bus.line_valid && rdy && !bus.line_half;
    assign cap1     = bus.line_valid && rdy && bus.line_half;
    assign shifting = state == SHIFT_0 || state == SHIFT_1;
    assign fire     = shifting && bus.elem_ready;
    assign last     = idx == count - 6'd1;

    // In SHIFT_1 idx runs HE..2*HE-1, so its low bits already index half 1 directly
    assign cur = state == SHIFT_1 ? buf1 : buf0;
    for (genvar g = 0; g < HE; g++) begin : g_word
        assign words[g] = cur[g*EW +: EW];
    end
    assign raw = words[idx[KW-1:0]];
    for (genvar b = 0; b < ELEM_BYTES; b++) begin : g_swap
        assign swap[b*8 +: 8] = raw[(ELEM_BYTES-1-b)*8 +: 8];
    end

    assign bus.cmd_ready  = state == IDLE;
    assign bus.line_ready = rdy;
    assign bus.err_stray  = bus.line_valid && !rdy;
    assign bus.elem_valid = shifting;
    assign bus.elem_data  = shifting ? swap : '0;
    assign bus.elem_index = shifting ? idx : '0;
    assign bus.elem_last  = shifting && last;

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state: wait for required halves, walk half 0 then half 1, one DONE cycle
    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = (bus.cmd_valid && bus.cmd_count != '0) ? WAIT_DATA : IDLE;
            WAIT_DATA: state_n = ((got0 || cap0) && (!need1 || got1 || cap1)) ? SHIFT_0 : WAIT_DATA;
            SHIFT_0:   state_n = !fire ? SHIFT_0 : last ? DONE : (idx == HE_LAST) ? SHIFT_1 : SHIFT_0;
            SHIFT_1:   state_n = !fire ? SHIFT_1 : last ? DONE : SHIFT_1;
            DONE:      state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    // Command latch, half capture and element counter; DONE clears the line
    always_ff @(posedge clock) begin
        if (reset || state == DONE) begin
            got0 <= 1'b0;
            got1 <= 1'b0;
            buf0 <= '0;
            buf1 <= '0;
            idx  <= '0;
            if (reset) begin
                count <= '0;
                need1 <= 1'b0;
            end
        end else begin
            if (state == IDLE && bus.cmd_valid) begin
                count <= bus.cmd_count;
                need1 <= bus.cmd_count > HE_CNT;
            end
            if (cap0) begin
                buf0 <= bus.line_data;
                got0 <= 1'b1;
            end
            if (cap1) begin
                buf1 <= bus.line_data;
                got1 <= 1'b1;
            end
            if (fire) idx <= idx + 6'd1;
        end
    end
endmodule

// File: tb/tb_cu_read_line_unpacker.sv
// tb_cu_read_line_unpacker: randomized line traffic checked against a queue-based element model
module tb_cu_read_line_unpacker;
    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    cu_read_line_unpacker_if #(.ELEM_BYTES(4), .HALF_BYTES(64)) bus();

    cu_read_line_unpacker #(.ELEM_BYTES(4), .HALF_BYTES(64)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] d;
        logic [5:0]  i;
        logic        l;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    bit          exp_stray = 1'b0;
    int          rdy_mode = 0;
    logic [31:0] w [32];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Downstream readiness pattern
    initial begin
        bus.elem_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            bus.elem_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ~bus.elem_ready : 1'($urandom_range(0, 1));
        end
    end

    // Every valid cycle must present the head of the expected stream; stray halves must be flagged
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.elem_valid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL elem_unexpected actual index=%0d data=%0h required no element", bus.elem_index, bus.elem_data);
                end else begin
                    chk("elem_data", bus.elem_data, q[0].d);
                    chk("elem_index", bus.elem_index, q[0].i);
                    chk("elem_last", bus.elem_last, q[0].l);
                    if (bus.elem_ready) void'(q.pop_front());
                end
            end
            if (bus.line_valid) begin
                chk("line_ready", bus.line_ready, !exp_stray);
                chk("err_stray", bus.err_stray, exp_stray);
            end else begin
                chk("err_stray_idle", bus.err_stray, 0);
            end
        end
    end

    task automatic issue(input int c);
        @(posedge clock);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_count = 6'(c);
        @(negedge clock);
        chk("cmd_ready_at_issue", bus.cmd_ready, 1);
        @(posedge clock);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send_line(input int c, input int order, input bit stray, input bit pin);
        int          seq[$];
        bit          sq[$];
        logic [511:0] hd;
        for (int i = 0; i < 32; i++) w[i] = $urandom;
        if (pin) w[0] = 32'h11223344;
        if (c > 16) begin
            seq.push_back(order); sq.push_back(1'b0);
            if (stray) begin seq.push_back(order); sq.push_back(1'b1); end
            seq.push_back(1 - order); sq.push_back(1'b0);
        end else begin
            if (stray) begin seq.push_back(1); sq.push_back(1'b1); end
            seq.push_back(0); sq.push_back(1'b0);
        end
        for (int j = 0; j < seq.size(); j++) begin
            for (int k = 0; k < 16; k++) hd[k*32 +: 32] = w[seq[j]*16 + k];
            if (sq[j]) hd = {16{$urandom}};
            bus.line_valid = 1'b1;
            bus.line_half  = 1'(seq[j]);
            bus.line_data  = hd;
            exp_stray      = sq[j];
            if (j == seq.size() - 1)
                for (int i = 0; i < c; i++) q.push_back('{bswap(w[i]), 6'(i), i == c - 1});
            @(negedge clock);
            if (j == seq.size() - 1) chk("no_early_elem", bus.elem_valid, 0);
            @(posedge clock);
            #1;
            bus.line_valid = 1'b0;
            exp_stray      = 1'b0;
            if (j != seq.size() - 1)
                repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
        end
    endtask

    task automatic drain(input int c, input int mode, input bit pin);
        bit seen;
        int n = 0;
        @(negedge clock);
        chk("latency_valid", bus.elem_valid, 1);
        if (pin) begin
            chk("pin_data", bus.elem_data, 32'h44332211);
            chk("pin_index", bus.elem_index, 0);
        end
        seen = bus.elem_valid && bus.elem_ready && bus.elem_last;
        while (!seen && n < 600) begin
            @(posedge clock);
            #1;
            bus.line_valid = ($urandom_range(0, 7) == 0);
            bus.line_half  = 1'($urandom_range(0, 1));
            bus.line_data  = {16{$urandom}};
            exp_stray      = bus.line_valid;
            @(negedge clock);
            n++;
            seen = bus.elem_valid && bus.elem_ready && bus.elem_last;
        end
        chk("drain_done", seen, 1);
        if (mode == 0) chk("throughput", n, c - 1);
        @(posedge clock);
        #1;
        bus.line_valid = 1'b0;
        exp_stray      = 1'b0;
        @(negedge clock);
        chk("done_cmd_ready", bus.cmd_ready, 0);
        chk("done_no_valid", bus.elem_valid, 0);
        @(negedge clock);
        chk("idle_cmd_ready", bus.cmd_ready, 1);
    endtask

    task automatic cmd(input int c, input int order, input bit stray, input int mode, input bit pin);
        rdy_mode = mode;
        issue(c);
        if (c == 0) begin
            repeat (3) begin
                @(negedge clock);
                chk("zero_cmd_ready", bus.cmd_ready, 1);
                chk("zero_no_valid", bus.elem_valid, 0);
            end
        end else begin
            send_line(c, order, stray, pin);
            drain(c, mode, pin);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=expired required=finish");
        $fatal(1);
    end

    initial begin
        int n;
        bit hit;
        bus.cmd_valid  = 1'b0;
        bus.cmd_count  = '0;
        bus.line_valid = 1'b0;
        bus.line_half  = 1'b0;
        bus.line_data  = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_elem_valid", bus.elem_valid, 0);
        chk("rst_line_ready", bus.line_ready, 0);
        chk("rst_elem_last", bus.elem_last, 0);
        chk("rst_elem_index", bus.elem_index, 0);
        chk("rst_elem_data", bus.elem_data, 0);

        cmd(5, 0, 0, 0, 1);
        cmd(32, 1, 0, 0, 0);
        cmd(20, 0, 0, 1, 0);
        cmd(8, 0, 1, 0, 0);
        cmd(24, 0, 1, 2, 0);
        cmd(16, 1, 1, 0, 0);
        cmd(17, 1, 0, 0, 0);
        cmd(1, 0, 0, 1, 0);

        rdy_mode = 0;
        issue(20);
        send_line(20, 0, 0, 0);
        n = 0;
        hit = 0;
        while (!hit && n < 200) begin
            @(negedge clock);
            n++;
            hit = bus.elem_valid && bus.elem_ready && bus.elem_index == 6'd17;
        end
        chk("reach_index_17", hit, 1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        q.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("mid_rst_elem_valid", bus.elem_valid, 0);
        chk("mid_rst_cmd_ready", bus.cmd_ready, 1);
        chk("mid_rst_elem_last", bus.elem_last, 0);
        cmd(3, 0, 0, 0, 0);
        cmd(0, 0, 0, 0, 0);

        for (int r = 0; r < 30; r++) begin
            int c;
            c = ($urandom_range(0, 8) == 0) ? 0 : $urandom_range(1, 32);
            cmd(c, $urandom_range(0, 1), 1'($urandom_range(0, 1)), $urandom_range(0, 2), 0);
        end

        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
